vga_bounce_gen: RTL and testbench
=================================

VGA_BOUNCE_GEN -- requirements
Module: vga_bounce_gen

Interface
REQ-001 The parameter H_DISPLAY SHALL default to 640 and set the visible width in pixels.
REQ-002 The parameter V_DISPLAY SHALL default to 480 and set the visible height in lines.
REQ-003 The parameter BOX_SIZE SHALL default to 32 and set the square sprite edge in pixels.
REQ-004 The parameter STEP SHALL default to 2 and set the sprite displacement per frame, per axis, in pixels.
REQ-005 The port clk SHALL be an input, 1 bit wide, carrying the pixel clock.
REQ-006 The port rst SHALL be an input, 1 bit wide, carrying the asynchronous, active-high reset.
REQ-007 The port pixel_x SHALL be an input, 10 bits wide, carrying the current column from the sync generator.
REQ-008 The port pixel_y SHALL be an input, 10 bits wide, carrying the current row from the sync generator.
REQ-009 The port video_on SHALL be an input, 1 bit wide, that is high inside the visible area.
REQ-010 The port h_sync_in SHALL be an input, 1 bit wide, carrying the active-low horizontal sync from the sync generator.
REQ-011 The port v_sync_in SHALL be an input, 1 bit wide, carrying the active-low vertical sync from the sync generator.
REQ-012 The port run SHALL be an input, 1 bit wide; high lets the sprite move and low freezes it.
REQ-013 The port rgb SHALL be an output, 12 bits wide, carrying the registered colour as R[11:8], G[7:4], B[3:0].
REQ-014 The port h_sync_out SHALL be an output, 1 bit wide, carrying h_sync_in delayed by one clk.
REQ-015 The port v_sync_out SHALL be an output, 1 bit wide, carrying v_sync_in delayed by one clk.
REQ-016 The port frame_tick SHALL be an output, 1 bit wide, carrying a one-clk pulse at each frame start.

Function
REQ-017 The frame start SHALL be defined as a 1->0 transition of v_sync_in, detected with a registered previous sample; frame_tick SHALL be high in the clk cycle after that sampled edge.
REQ-018 The state SHALL consist of box_x[9:0], box_y[9:0], dir_x and dir_y (1 = increasing), and col[2:0].
REQ-019 The state SHALL update only in the cycle where frame_tick asserts and run=1; otherwise it SHALL hold.
REQ-020 The x-axis update with dir_x=1 SHALL follow these rules.
- If box_x+STEP >= H_DISPLAY-BOX_SIZE: box_x <= H_DISPLAY-BOX_SIZE and dir_x <= 0 (wall hit).
- Otherwise: box_x <= box_x+STEP.
REQ-021 The x-axis update with dir_x=0 SHALL follow these rules.
- If box_x <= STEP: box_x <= 0 and dir_x <= 1 (wall hit).
- Otherwise: box_x <= box_x-STEP.
- The comparison SHALL use 11-bit arithmetic so that no underflow occurs.
REQ-022 The y axis SHALL follow the same rules as REQ-020 and REQ-021, using V_DISPLAY, box_y and dir_y.
REQ-023 Each update with at least one wall hit SHALL advance col by exactly 1; the sequence 7 SHALL wrap to 1, and col SHALL never be 0. A simultaneous x and y hit (corner) SHALL still advance col by exactly 1.
REQ-024 The pixel is inside the box when box_x <= pixel_x < box_x+BOX_SIZE and box_y <= pixel_y < box_y+BOX_SIZE.
REQ-025 The value of rgb, registered with 1-clk latency from its inputs, SHALL be selected in this priority order.
- When video_on=0: 12'h000.
- When inside the box: {4{col[2]},4{col[1]},4{col[0]}}.
- Otherwise: background 12'h008.
REQ-026 The outputs h_sync_out and v_sync_out SHALL be registered in the same cycle as rgb, so that all three stay aligned.
REQ-027 A position update SHALL take effect on pixels sampled from the cycle after frame_tick onward; the visible area of the new frame therefore always shows consistent coordinates.

Reset
REQ-028 While rst=1, the block SHALL hold these values.
- rgb = 0, h_sync_out = 1, v_sync_out = 1, frame_tick = 0.
- The previous-v_sync sample SHALL be 1.
- box_x = 0, box_y = 0, dir_x = 1, dir_y = 1, col = 3'b100 (red).
REQ-029 An assertion of rst mid-frame or mid-update SHALL override all pending updates; after release the block SHALL resume from the reset state, and the first frame_tick SHALL occur at the next v_sync_in falling edge.

Configuration
REQ-030 When BORDER_EN is defined, visible pixels with pixel_x==0, pixel_x==H_DISPLAY-1, pixel_y==0, or pixel_y==V_DISPLAY-1 SHALL output 12'hFFF, with priority over the box and background. When BORDER_EN is undefined, no border logic SHALL exist and REQ-025 SHALL apply unchanged.

Verification
REQ-031 Reset followed by the first v_sync_in fall with run=1 -> frame_tick for 1 clk; box_x=2, box_y=2, col=4.
REQ-032 Inputs pixel (5,5), video_on=1, with box at (0,0) and col=4 -> rgb=12'hF00 one clk later; pixel (40,5) -> 12'h008; video_on=0 -> 12'h000.
REQ-033 box_x=606 with dir_x=1 and a frame start -> box_x=608, dir_x=0, col advances; at the next frame box_x=606.
REQ-034 Box at (608,448) with both dirs=1 and a frame start -> corner hit: both dirs flip and col advances by exactly 1; col=7 advances to 1.
REQ-035 run=0 across 3 frame starts -> frame_tick pulses 3 times and box_x, box_y and col are unchanged.
REQ-036 rst asserted 100 clk after a frame start -> all outputs and state match REQ-028 within the same cycle; with BORDER_EN defined, pixel (0,200) -> 12'hFFF.

Source files
------------

// File: rtl/vga_bounce_gen.sv
// Bouncing-square sprite overlay for a VGA pixel stream; moves one STEP per frame and changes colour on wall hits.
// Optional white one-pixel screen border when the BORDER_EN macro is defined.
module vga_bounce_gen #(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        run,
    output logic [11:0] rgb,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        frame_tick
);

    localparam logic [10:0] X_MAX  = 11'(H_DISPLAY - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_DISPLAY - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

    logic        vSyncPrev_q;
    logic        frameTick_q;
    logic        hSync_q;
    logic        vSync_q;
    logic [11:0] rgb_q;
    logic [11:0] rgb_d;

    logic [9:0]  boxX_q, boxX_d;
    logic [9:0]  boxY_q, boxY_d;
    logic        dirX_q, dirX_d;
    logic        dirY_q, dirY_d;
    logic [2:0]  col_q,  col_d;

    logic        updateEn;
    logic        hitX;
    logic        hitY;
    logic        insideBox;

    assign updateEn = frameTick_q & run;

    // Position/direction candidates; 11-bit compares keep the low wall free of underflow.
    always_comb begin
        boxX_d = boxX_q;
        dirX_d = dirX_q;
        hitX   = 1'b0;
        boxY_d = boxY_q;
        dirY_d = dirY_q;
        hitY   = 1'b0;
        if (updateEn) begin
            if (dirX_q) begin
                if (({1'b0, boxX_q} + STEP_W) >= X_MAX) begin
                    boxX_d = X_MAX[9:0];
                    dirX_d = 1'b0;
                    hitX   = 1'b1;
                end else begin
                    boxX_d = boxX_q + STEP_W[9:0];
                end
            end else begin
                if ({1'b0, boxX_q} <= STEP_W) begin
                    boxX_d = '0;
                    dirX_d = 1'b1;
                    hitX   = 1'b1;
                end else begin
                    boxX_d = boxX_q - STEP_W[9:0];
                end
            end
            if (dirY_q) begin
                if (({1'b0, boxY_q} + STEP_W) >= Y_MAX) begin
                    boxY_d = Y_MAX[9:0];
                    dirY_d = 1'b0;
                    hitY   = 1'b1;
                end else begin
                    boxY_d = boxY_q + STEP_W[9:0];
                end
            end else begin
                if ({1'b0, boxY_q} <= STEP_W) begin
                    boxY_d = '0;
                    dirY_d = 1'b1;
                    hitY   = 1'b1;
                end else begin
                    boxY_d = boxY_q - STEP_W[9:0];
                end
            end
        end
    end

    // A corner hit is still a single colour step; the sequence skips black.
    always_comb begin
        col_d = col_q;
        if (updateEn && (hitX || hitY)) begin
            col_d = (col_q == 3'd7) ? 3'd1 : col_q + 3'd1;
        end
    end

    assign insideBox = ({1'b0, pixel_x} >= {1'b0, boxX_q}) &&
                       ({1'b0, pixel_x} <  ({1'b0, boxX_q} + BOX_W)) &&
                       ({1'b0, pixel_y} >= {1'b0, boxY_q}) &&
                       ({1'b0, pixel_y} <  ({1'b0, boxY_q} + BOX_W));

`ifdef BORDER_EN
    localparam logic [9:0] H_LAST = 10'(H_DISPLAY - 1);
    localparam logic [9:0] V_LAST = 10'(V_DISPLAY - 1);
    logic onBorder;
    assign onBorder = (pixel_x == '0) || (pixel_x == H_LAST) ||
                      (pixel_y == '0) || (pixel_y == V_LAST);
`endif

    always_comb begin
        rgb_d = 12'h008;
        if (!video_on) begin
            rgb_d = 12'h000;
        end
`ifdef BORDER_EN
        else if (onBorder) begin
            rgb_d = 12'hFFF;
        end
`endif
        else if (insideBox) begin
            rgb_d = {{4{col_q[2]}}, {4{col_q[1]}}, {4{col_q[0]}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vSyncPrev_q <= 1'b1;
            frameTick_q <= 1'b0;
            hSync_q     <= 1'b1;
            vSync_q     <= 1'b1;
            rgb_q       <= 12'h000;
            boxX_q      <= '0;
            boxY_q      <= '0;
            dirX_q      <= 1'b1;
            dirY_q      <= 1'b1;
            col_q       <= 3'b100;
        end else begin
            vSyncPrev_q <= v_sync_in;
            frameTick_q <= vSyncPrev_q & ~v_sync_in;
            hSync_q     <= h_sync_in;
            vSync_q     <= v_sync_in;
            rgb_q       <= rgb_d;
            boxX_q      <= boxX_d;
            boxY_q      <= boxY_d;
            dirX_q      <= dirX_d;
            dirY_q      <= dirY_d;
            col_q       <= col_d;
        end
    end

    assign rgb        = rgb_q;
    assign h_sync_out = hSync_q;
    assign v_sync_out = vSync_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Self-checking bench for vga_bounce_gen: sprite position/colour tracked by an arithmetic model and observed through rgb.
// Honours BORDER_EN in the model when the macro is defined.
module tb_vga_bounce_gen;

    localparam int H    = 640;
    localparam int V    = 480;
    localparam int BOX  = 32;
    localparam int STEP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        run;
    logic [11:0] rgb;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    int mX, mY, mC;
    bit mDx, mDy;

    always #5 clk = ~clk;

    vga_bounce_gen #(
        .H_DISPLAY(H),
        .V_DISPLAY(V),
        .BOX_SIZE (BOX),
        .STEP     (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .h_sync_in (h_sync_in),
        .v_sync_in (v_sync_in),
        .run       (run),
        .rgb       (rgb),
        .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out),
        .frame_tick(frame_tick)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void modelReset();
        mX = 0; mY = 0; mDx = 1'b1; mDy = 1'b1; mC = 4;
    endfunction

    // One moving frame: travel STEP toward the current wall, clamp and bounce if reached.
    function automatic bit modelFrame();
        bit hx = 1'b0;
        bit hy = 1'b0;
        if (mDx) begin
            if (mX + STEP >= H - BOX) begin mX = H - BOX; mDx = 1'b0; hx = 1'b1; end
            else mX = mX + STEP;
        end else begin
            if (mX - STEP <= 0) begin mX = 0; mDx = 1'b1; hx = 1'b1; end
            else mX = mX - STEP;
        end
        if (mDy) begin
            if (mY + STEP >= V - BOX) begin mY = V - BOX; mDy = 1'b0; hy = 1'b1; end
            else mY = mY + STEP;
        end else begin
            if (mY - STEP <= 0) begin mY = 0; mDy = 1'b1; hy = 1'b1; end
            else mY = mY - STEP;
        end
        if (hx || hy) mC = (mC == 7) ? 1 : mC + 1;
        return hx || hy;
    endfunction

    function automatic logic [11:0] expRgb(input int px, input int py, input bit vid);
        logic [11:0] c;
        if (!vid) return 12'h000;
`ifdef BORDER_EN
        if (px == 0 || px == H - 1 || py == 0 || py == V - 1) return 12'hFFF;
`endif
        if (px >= mX && px < mX + BOX && py >= mY && py < mY + BOX) begin
            c = 12'h000;
            if ((mC & 4) != 0) c = c | 12'hF00;
            if ((mC & 2) != 0) c = c | 12'h0F0;
            if ((mC & 1) != 0) c = c | 12'h00F;
            return c;
        end
        return 12'h008;
    endfunction

    // Probe points hugging the model's box edges, plus one random pixel.
    function automatic void boxPoint(input int k, output int px, output int py);
        case (k)
            0: begin px = mX;           py = mY;           end
            1: begin px = mX + BOX - 1; py = mY + BOX - 1; end
            2: begin px = mX - 1;       py = mY + 3;       end
            3: begin px = mX + BOX;     py = mY + BOX - 1; end
            4: begin px = mX + 5;       py = mY - 1;       end
            5: begin px = mX + BOX - 1; py = mY + BOX;     end
            default: begin
                px = int'($urandom_range(0, H - 1));
                py = int'($urandom_range(0, V - 1));
            end
        endcase
        if (px < 0) px = mX + BOX;
        if (py < 0) py = mY + BOX;
    endfunction

    task automatic drivePixel(input int px, input int py, input bit vid,
                              output logic [11:0] gotRgb, output logic gotHs, output logic expHs);
        pixel_x   = 10'(px);
        pixel_y   = 10'(py);
        video_on  = vid;
        h_sync_in = 1'($urandom_range(0, 1));
        expHs     = h_sync_in;
        cycle();
        gotRgb = rgb;
        gotHs  = h_sync_out;
    endtask

    task automatic frameStart(output int ticks, output logic firstTick, output logic vsLow);
        ticks = 0;
        v_sync_in = 1'b0;
        cycle();
        firstTick = frame_tick;
        vsLow     = ~v_sync_out;
        ticks += int'(frame_tick);
        cycle();
        ticks += int'(frame_tick);
        v_sync_in = 1'b1;
        cycle();
        ticks += int'(frame_tick);
        cycle();
        ticks += int'(frame_tick);
    endtask

    task automatic test_reset();
        rst = 1'b1; h_sync_in = 1'b0; video_on = 1'b1; pixel_x = 10'd5; pixel_y = 10'd5;
        v_sync_in = 1'b0;
        cycle();
        cycle();
        checks++; if (rgb !== 12'h000) begin failures++; $display("[TB] FAIL reset_rgb got=%h exp=000", rgb); end
        checks++; if (h_sync_out !== 1'b1) begin failures++; $display("[TB] FAIL reset_hsync got=%b exp=1", h_sync_out); end
        checks++; if (v_sync_out !== 1'b1) begin failures++; $display("[TB] FAIL reset_vsync got=%b exp=1", v_sync_out); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("[TB] FAIL reset_tick got=%b exp=0", frame_tick); end
        v_sync_in = 1'b1;
        cycle();
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_pixels_after_reset();
        int px[4] = '{5, 40, 5, 0};
        int py[4] = '{5, 5, 5, 200};
        bit vd[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [11:0] got;
        logic gotHs, expHs;
        for (int i = 0; i < 4; i++) begin
            drivePixel(px[i], py[i], vd[i], got, gotHs, expHs);
            checks++;
            if (got !== expRgb(px[i], py[i], vd[i])) begin
                failures++;
                $display("[TB] FAIL init_pixel(%0d,%0d,vid=%0d) rgb got=%h exp=%h", px[i], py[i], vd[i], got, expRgb(px[i], py[i], vd[i]));
            end
            checks++;
            if (gotHs !== expHs) begin failures++; $display("[TB] FAIL init_hsync got=%b exp=%b", gotHs, expHs); end
        end
    endtask

    task automatic test_first_frame();
        int ticks, qx, qy;
        logic first, vsLow, gotHs, expHs;
        logic [11:0] got;
        bit hit;
        run = 1'b1;
        frameStart(ticks, first, vsLow);
        checks++; if (first !== 1'b1) begin failures++; $display("[TB] FAIL first_tick_timing got=%b exp=1", first); end
        checks++; if (ticks != 1) begin failures++; $display("[TB] FAIL first_tick_count got=%0d exp=1", ticks); end
        checks++; if (vsLow !== 1'b1) begin failures++; $display("[TB] FAIL vsync_delay got_low=%b exp=1", vsLow); end
        hit = modelFrame();
        for (int k = 0; k < 7; k++) begin
            boxPoint(k, qx, qy);
            drivePixel(qx, qy, 1'b1, got, gotHs, expHs);
            checks++;
            if (got !== expRgb(qx, qy, 1'b1)) begin
                failures++;
                $display("[TB] FAIL first_frame_box(%0d,%0d) rgb got=%h exp=%h hit=%0d", qx, qy, got, expRgb(qx, qy, 1'b1), hit);
            end
        end
    endtask

    task automatic test_sweep();
        int ticks, qx, qy, corners;
        logic first, vsLow, gotHs, expHs;
        logic [11:0] got;
        bit hit, wasDx, wasDy;
        corners = 0;
        run = 1'b1;
        for (int f = 2; f <= 4300; f++) begin
            frameStart(ticks, first, vsLow);
            checks++;
            if (ticks != 1 || first !== 1'b1) begin
                failures++;
                $display("[TB] FAIL sweep_tick frame=%0d got_count=%0d first=%b exp 1/1", f, ticks, first);
            end
            wasDx = mDx; wasDy = mDy;
            hit = modelFrame();
            if (wasDx != mDx && wasDy != mDy) corners++;
            if (hit || (f % 53) == 0) begin
                for (int k = 0; k < 7; k++) begin
                    boxPoint(k, qx, qy);
                    drivePixel(qx, qy, 1'b1, got, gotHs, expHs);
                    checks++;
                    if (got !== expRgb(qx, qy, 1'b1)) begin
                        failures++;
                        $display("[TB] FAIL sweep_box frame=%0d pix(%0d,%0d) rgb got=%h exp=%h box=(%0d,%0d) col=%0d",
                                 f, qx, qy, got, expRgb(qx, qy, 1'b1), mX, mY, mC);
                    end
                    checks++;
                    if (gotHs !== expHs) begin failures++; $display("[TB] FAIL sweep_hsync got=%b exp=%b", gotHs, expHs); end
                end
            end
        end
        if (corners == 0) $display("[TB] note: no corner bounce occurred in sweep");
    endtask

    task automatic test_run_freeze();
        int ticks, total, qx, qy;
        logic first, vsLow, gotHs, expHs;
        logic [11:0] got;
        total = 0;
        run = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frameStart(ticks, first, vsLow);
            total += ticks;
        end
        checks++; if (total != 3) begin failures++; $display("[TB] FAIL freeze_ticks got=%0d exp=3", total); end
        for (int k = 0; k < 7; k++) begin
            boxPoint(k, qx, qy);
            drivePixel(qx, qy, 1'b1, got, gotHs, expHs);
            checks++;
            if (got !== expRgb(qx, qy, 1'b1)) begin
                failures++;
                $display("[TB] FAIL freeze_box pix(%0d,%0d) rgb got=%h exp=%h", qx, qy, got, expRgb(qx, qy, 1'b1));
            end
        end
        run = 1'b1;
    endtask

    task automatic test_random_pixels();
        int qx, qy;
        bit vid;
        logic gotHs, expHs;
        logic [11:0] got;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                qx = mX + int'($urandom_range(0, 2 * BOX)) - BOX / 2;
                qy = mY + int'($urandom_range(0, 2 * BOX)) - BOX / 2;
                if (qx < 0) qx = 0;
                if (qy < 0) qy = 0;
            end else begin
                qx = int'($urandom_range(0, H - 1));
                qy = int'($urandom_range(0, V - 1));
            end
            vid = ($urandom_range(0, 3) != 0);
            drivePixel(qx, qy, vid, got, gotHs, expHs);
            checks++;
            if (got !== expRgb(qx, qy, vid)) begin
                failures++;
                $display("[TB] FAIL random_pixel(%0d,%0d,vid=%0d) rgb got=%h exp=%h", qx, qy, vid, got, expRgb(qx, qy, vid));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int ticks, qx, qy;
        logic first, vsLow, gotHs, expHs;
        logic [11:0] got;
        bit hit;
        frameStart(ticks, first, vsLow);
        hit = modelFrame();
        for (int i = 0; i < 99; i++) begin
            pixel_x = 10'(mX + 1); pixel_y = 10'(mY + 1); video_on = 1'b1; h_sync_in = 1'b0;
            cycle();
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (rgb !== 12'h000) begin failures++; $display("[TB] FAIL midreset_rgb got=%h exp=000", rgb); end
        checks++; if (h_sync_out !== 1'b1) begin failures++; $display("[TB] FAIL midreset_hsync got=%b exp=1", h_sync_out); end
        checks++; if (v_sync_out !== 1'b1) begin failures++; $display("[TB] FAIL midreset_vsync got=%b exp=1", v_sync_out); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("[TB] FAIL midreset_tick got=%b exp=0", frame_tick); end
        cycle();
        cycle();
        rst = 1'b0;
        modelReset();
        for (int k = 0; k < 7; k++) begin
            boxPoint(k, qx, qy);
            drivePixel(qx, qy, 1'b1, got, gotHs, expHs);
            checks++;
            if (got !== expRgb(qx, qy, 1'b1)) begin
                failures++;
                $display("[TB] FAIL postreset_box pix(%0d,%0d) rgb got=%h exp=%h", qx, qy, got, expRgb(qx, qy, 1'b1));
            end
        end
        drivePixel(0, 200, 1'b1, got, gotHs, expHs);
        checks++;
        if (got !== expRgb(0, 200, 1'b1)) begin failures++; $display("[TB] FAIL postreset_edge_pixel rgb got=%h exp=%h", got, expRgb(0, 200, 1'b1)); end
        frameStart(ticks, first, vsLow);
        checks++;
        if (ticks != 1 || first !== 1'b1) begin failures++; $display("[TB] FAIL postreset_tick count=%0d first=%b exp 1/1", ticks, first); end
        hit = modelFrame();
        for (int k = 0; k < 6; k++) begin
            boxPoint(k, qx, qy);
            drivePixel(qx, qy, 1'b1, got, gotHs, expHs);
            checks++;
            if (got !== expRgb(qx, qy, 1'b1)) begin
                failures++;
                $display("[TB] FAIL postreset_frame pix(%0d,%0d) rgb got=%h exp=%h", qx, qy, got, expRgb(qx, qy, 1'b1));
            end
        end
    endtask

    initial begin
        rst = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        h_sync_in = 1'b1; v_sync_in = 1'b1; run = 1'b1;
        modelReset();
        test_reset();
        test_pixels_after_reset();
        test_first_frame();
        test_sweep();
        test_run_freeze();
        test_random_pixels();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
